// File: rtl/kernel_cc_pkg.sv
// Shared definitions for the kernel start arbiter: FSM encoding and parameter defaults.
package kernel_cc_pkg;
  localparam int NUM_REQ_DEF   = 4;
  localparam int ID_WIDTH_DEF  = 2;
  localparam int DEPTH_DEF     = 4;
  localparam int CNT_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/kernel_cc_rr_pick.sv
// Combinational round-robin pick: first set bit of pending at or after rr_ptr, wrapping.
module kernel_cc_rr_pick
  import kernel_cc_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic [NUM_REQ-1:0]  pending,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                valid,
  output logic [ID_WIDTH-1:0] idx
);

  function automatic int wrap(input int a);
    return (a >= NUM_REQ) ? a - NUM_REQ : a;
  endfunction

  // Scan from the farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (pending[wrap(int'(rr_ptr) + off)]) begin
        valid = 1'b1;
        idx   = ID_WIDTH'(wrap(int'(rr_ptr) + off));
      end
    end
  end

endmodule

// File: rtl/kernel_cc_start_arbiter.sv
// Round-robin start arbiter: grants pending requesters into a start FIFO with credit tracking.
module kernel_cc_start_arbiter
  import kernel_cc_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ID_WIDTH  = ID_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   ack,
  input  logic                 flush,
  input  logic                 fifo_full_n,
  output logic                 fifo_write,
  output logic                 fifo_write_ce,
  output logic [ID_WIDTH-1:0]  fifo_din,
  input  logic                 fifo_rd_evt,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 busy,
  output logic                 ovf_err
);

  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
  state_e               state_q, state_d;
  logic                 fifo_write_q;
  logic [ID_WIDTH-1:0]  fifo_din_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 ovf_q, ovf_d;

  logic                 pick_vld;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 grant;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 rd_ok;

  kernel_cc_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .valid   (pick_vld),
    .idx     (pick_idx)
  );

  assign grant  = pick_vld && !flush && (outstanding_q < CNT_WIDTH'(DEPTH));
  assign gnt_oh = grant ? (NUM_REQ'(1) << pick_idx) : '0;
  assign rd_ok  = fifo_rd_evt && (outstanding_q != '0);

  always_comb begin
    // A granted requester drops out immediately so it cannot win again while its ack is in flight.
    pending_d = flush ? '0 : ((pending_q | (req & ~ack_q)) & ~gnt_oh);

    rr_ptr_d = rr_ptr_q;
    if (grant)
      rr_ptr_d = (pick_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + ID_WIDTH'(1);

    outstanding_d = outstanding_q;
    case ({grant, rd_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_WIDTH'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_WIDTH'(1);
      default: outstanding_d = outstanding_q;
    endcase

    ovf_d = ovf_q | (fifo_write_q & ~fifo_full_n);
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (pending_q != '0 || outstanding_q != '0) state_d = RUN;
        RUN:     if (pending_q == '0 && outstanding_q == '0) state_d = IDLE;
        FLUSH:   state_d = (outstanding_q == '0) ? IDLE : RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      state_q       <= IDLE;
      fifo_write_q  <= 1'b0;
      fifo_din_q    <= '0;
      ack_q         <= '0;
      ovf_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      state_q       <= state_d;
      fifo_write_q  <= grant;
      ack_q         <= gnt_oh;
      ovf_q         <= ovf_d;
      if (grant) fifo_din_q <= pick_idx;
    end
  end

  assign ack           = ack_q;
  assign fifo_write    = fifo_write_q;
  assign fifo_write_ce = 1'b1;
  assign fifo_din      = fifo_din_q;
  assign outstanding   = outstanding_q;
  assign busy          = (state_q != IDLE);
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_kernel_cc_start_arbiter.sv
// Bench for kernel_cc_start_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_kernel_cc_start_arbiter;
  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic           flush;
  logic           fifo_full_n;
  logic           fifo_write;
  logic           fifo_write_ce;
  logic [IDW-1:0] fifo_din;
  logic           fifo_rd_evt;
  logic [CW-1:0]  outstanding;
  logic           busy;
  logic           ovf_err;

  int n_cmp = 0;
  int n_bad = 0;

  kernel_cc_start_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IDW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .flush(flush),
    .fifo_full_n(fifo_full_n), .fifo_write(fifo_write), .fifo_write_ce(fifo_write_ce),
    .fifo_din(fifo_din), .fifo_rd_evt(fifo_rd_evt), .outstanding(outstanding),
    .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pending set, round-robin start point, token count, mode (0 idle,1 run,2 flush),
  // and the registered write/ID/error the outputs must show.
  typedef struct {
    logic [N-1:0] pend;
    int rr;
    int outst;
    int st;
    bit wr;
    int din;
    bit ovf;
  } model_t;

  function automatic model_t m_rst();
    model_t r;
    r.pend = '0; r.rr = 0; r.outst = 0; r.st = 0; r.wr = 0; r.din = 0; r.ovf = 0;
    return r;
  endfunction

  function automatic model_t mstep(input model_t m, input logic [N-1:0] rq,
                                   input bit fl, input bit rd, input bit fn);
    model_t n = m;
    int g = -1;
    if (!fl && m.outst < DEPTH)
      for (int k = 0; k < N; k++) begin
        int c = (m.rr + k) % N;
        if (g < 0 && m.pend[c]) g = c;
      end
    n.ovf = m.ovf | (m.wr && !fn);
    for (int i = 0; i < N; i++)
      n.pend[i] = fl ? 1'b0 : ((m.pend[i] || (rq[i] && !(m.wr && m.din == i))) && i != g);
    if (fl)             n.st = 2;
    else if (m.st == 0) n.st = (m.pend != 0 || m.outst > 0) ? 1 : 0;
    else if (m.st == 1) n.st = (m.pend == 0 && m.outst == 0) ? 0 : 1;
    else                n.st = (m.outst == 0) ? 0 : 1;
    n.outst = m.outst + ((g >= 0) ? 1 : 0) - ((rd && m.outst > 0) ? 1 : 0);
    n.wr = (g >= 0);
    if (g >= 0) begin
      n.din = g;
      n.rr  = (g + 1) % N;
    end
    return n;
  endfunction

  model_t m;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) m <= m_rst();
    else          m <= mstep(m, req, flush, fifo_rd_evt, fifo_full_n);

  always @(negedge clk) begin
    chk("fifo_write", int'(fifo_write), int'(m.wr));
    chk("ack", int'(ack), m.wr ? (1 << m.din) : 0);
    if (m.wr) chk("fifo_din", int'(fifo_din), m.din);
    chk("outstanding", int'(outstanding), m.outst);
    chk("busy", int'(busy), (m.st != 0) ? 1 : 0);
    chk("ovf_err", int'(ovf_err), int'(m.ovf));
    chk("fifo_write_ce", int'(fifo_write_ce), 1);
    chk("state", int'(dut.state_q), m.st);
    chk("pending", int'(dut.pending_q), int'(m.pend));
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0; flush = 1'b0; fifo_rd_evt = 1'b0; fifo_full_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; req = '0; flush = 1'b0; fifo_rd_evt = 1'b0; fifo_full_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_write", int'(fifo_write), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_din", int'(fifo_din), 0);
    chk("rst_outst", int'(outstanding), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf_err), 0);
    reset_n = 1'b1;

    // Single request: write two edges after req rises.
    req = 4'b0001;
    @(negedge clk); chk("single_e1_write", int'(fifo_write), 0); req = '0;
    @(negedge clk);
    chk("single_write", int'(fifo_write), 1);
    chk("single_ack", int'(ack), 1);
    chk("single_din", int'(fifo_din), 0);
    chk("single_outst", int'(outstanding), 1);
    @(negedge clk); chk("single_pulse_end", int'(fifo_write), 0); fifo_rd_evt = 1'b1;
    @(negedge clk); chk("single_drain", int'(outstanding), 0); fifo_rd_evt = 1'b0;

    // Fairness and credit stall.
    do_reset();
    req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fair_write", int'(fifo_write), 1);
      chk("fair_din", int'(fifo_din), k);
    end
    chk("fair_outst4", int'(outstanding), 4);
    @(negedge clk); chk("fair_stall_a", int'(fifo_write), 0);
    @(negedge clk); chk("fair_stall_b", int'(fifo_write), 0); chk("fair_stall_outst", int'(outstanding), 4);
    fifo_rd_evt = 1'b1;
    @(negedge clk); fifo_rd_evt = 1'b0;
    chk("credit_outst3", int'(outstanding), 3); chk("credit_nowr", int'(fifo_write), 0);
    @(negedge clk);
    chk("credit_write", int'(fifo_write), 1); chk("credit_din", int'(fifo_din), 0);
    chk("credit_outst4", int'(outstanding), 4);
    @(negedge clk); chk("credit_single", int'(fifo_write), 0);

    // Grant and read in the same cycle.
    do_reset();
    req = 4'b0011;
    @(negedge clk); req = '0;
    @(negedge clk);
    @(negedge clk); chk("simul_outst2", int'(outstanding), 2); req = 4'b0100;
    @(negedge clk); req = '0; fifo_rd_evt = 1'b1;
    @(negedge clk); fifo_rd_evt = 1'b0;
    chk("simul_write", int'(fifo_write), 1); chk("simul_din", int'(fifo_din), 2);
    chk("simul_outst", int'(outstanding), 2);

    // Flush with pending requesters.
    do_reset();
    req = 4'b0110;
    @(negedge clk); chk("flush_pend_pre", int'(dut.pending_q), 6); req = '0; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_ack", int'(ack), 0);
      chk("flush_pend", int'(dut.pending_q), 0);
      chk("flush_state", int'(dut.state_q), 2);
    end
    flush = 1'b0;
    @(negedge clk); chk("flush_idle", int'(busy), 0); chk("flush_ack_after", int'(ack), 0);

    // Overflow error, then reset in the middle of a grant.
    do_reset();
    req = 4'b0001;
    @(negedge clk); req = '0;
    @(negedge clk); chk("ovf_wr", int'(fifo_write), 1); fifo_full_n = 1'b0;
    @(negedge clk); chk("ovf_set", int'(ovf_err), 1); fifo_full_n = 1'b1; req = 4'b0010;
    @(negedge clk); req = '0;
    @(negedge clk); chk("mid_write", int'(fifo_write), 1); chk("mid_din", int'(fifo_din), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_write", int'(fifo_write), 0);
    chk("arst_ack", int'(ack), 0);
    chk("arst_din", int'(fifo_din), 0);
    chk("arst_outst", int'(outstanding), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ovf", int'(ovf_err), 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); chk("arst_no_ack", int'(ack), 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req         = N'($urandom);
      flush       = ($urandom_range(0, 19) == 0);
      fifo_rd_evt = ($urandom_range(0, 2) == 0);
      fifo_full_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kernel_cc_start_arbiter.md
KERNEL_CC_START_ARBITER -- requirements
Module: kernel_cc_start_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesting dataflow processes.
REQ-002 SHALL have parameter ID_WIDTH, default 2: width of the requester ID token, equal to clog2(NUM_REQ).
REQ-003 SHALL have parameter DEPTH, default 4: depth of the downstream start FIFO.
REQ-004 SHALL have parameter CNT_WIDTH, default 3: outstanding-counter width, able to hold 0..DEPTH.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port req, input, NUM_REQ bits: level start request per process.
REQ-009 SHALL have port ack, output, NUM_REQ bits: one-cycle pulse when that requester's token is written.
REQ-010 SHALL have port flush, input, 1 bit: drop all pending requests and block new grants.
REQ-011 SHALL have port fifo_full_n, input, 1 bit: start FIFO not-full; observed for error detection only.
REQ-012 SHALL have port fifo_write, output, 1 bit: start FIFO write strobe.
REQ-013 SHALL have port fifo_write_ce, output, 1 bit: tied to 1.
REQ-014 SHALL have port fifo_din, output, ID_WIDTH bits: granted requester ID.
REQ-015 SHALL have port fifo_rd_evt, input, 1 bit: consumer pop, equal to read AND read_ce AND empty_n.
REQ-016 SHALL have port outstanding, output, CNT_WIDTH bits: tokens currently in the FIFO.
REQ-017 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-018 SHALL have port ovf_err, output, 1 bit: sticky flag for a write issued while the FIFO is full.

Function
REQ-019 SHALL set pending[i] in any cycle where req[i]=1, flush=0 and no ack[i] is issued that cycle; pending[i] SHALL clear on ack[i].
REQ-020 SHALL consider a grant eligible in a cycle where pending is non-zero, flush=0 and outstanding<DEPTH.
REQ-021 SHALL grant the first pending index at or after rr_ptr, searching modulo NUM_REQ.
REQ-022 SHALL register the grant, so an eligible cycle N produces fifo_write=1, fifo_din=i and ack[i]=1 in cycle N+1, each asserted for exactly one cycle.
REQ-023 SHALL update rr_ptr to (i+1) mod NUM_REQ on each grant, and SHALL otherwise hold rr_ptr.
REQ-024 SHALL update outstanding on the grant edge: +1 on a grant alone, -1 on fifo_rd_evt alone, unchanged when both occur in the same cycle, and never wrapping.
REQ-025 SHALL ignore fifo_rd_evt when outstanding=0.
REQ-026 SHALL permit at most one grant per cycle, and SHALL permit back-to-back grants in consecutive cycles.
REQ-027 SHALL set ovf_err, and hold it until reset, if fifo_write=1 while fifo_full_n=0.
REQ-028 SHALL implement states IDLE, RUN and FLUSH.
REQ-029 SHALL move IDLE->RUN on any pending bit or outstanding>0.
REQ-030 SHALL move RUN->IDLE when pending=0 and outstanding=0.
REQ-031 SHALL move from any state to FLUSH when flush=1.
REQ-032 SHALL move FLUSH->IDLE when flush=0 and outstanding=0, and FLUSH->RUN when flush=0 and outstanding>0.
REQ-033 SHALL clear all pending bits on the first flush cycle and issue no grant while flush=1; a grant already registered before flush rises SHALL still complete.
REQ-034 SHALL make ack and fifo_write mutually consistent: ack is one-hot and non-zero exactly when fifo_write=1.

Reset
REQ-035 SHALL, while reset_n=0, asynchronously drive pending=0, rr_ptr=0, outstanding=0, state=IDLE, fifo_write=0, fifo_din=0, ack=0 and ovf_err=0.
REQ-036 SHALL discard any in-flight grant on reset, with no ack issued.
REQ-037 SHALL recognise the first grant no earlier than the first rising edge after reset_n rises.

Structure
REQ-038 SHALL place state encodings (IDLE=0, RUN=1, FLUSH=2) and the defaults for NUM_REQ, DEPTH, ID_WIDTH and CNT_WIDTH in the shared package kernel_cc_pkg.
REQ-039 SHALL implement the round-robin priority search as the combinational sub-module kernel_cc_rr_pick (inputs pending and rr_ptr; outputs valid and idx).
REQ-040 SHALL keep all sequential state in kernel_cc_start_arbiter.

Verification
REQ-041 SHALL verify single request: req=0001 -> fifo_write and ack[0] pulse two edges after req rises, fifo_din=0, outstanding=1.
REQ-042 SHALL verify fairness: req=1111 held, no reads, DEPTH=4 -> grant IDs 0,1,2,3 on consecutive cycles, then no grant while outstanding=4.
REQ-043 SHALL verify credit: with outstanding=4, pulse fifo_rd_evt once -> exactly one new grant follows, and outstanding returns to 4.
REQ-044 SHALL verify simultaneous events: a grant and fifo_rd_evt in the same cycle with outstanding=2 -> outstanding stays 2.
REQ-045 SHALL verify flush: pending=0110 and flush held 3 cycles -> no ack, pending=0, state FLUSH, then IDLE once flush=0 and outstanding=0.
REQ-046 SHALL verify reset and error: forcing fifo_full_n=0 during a write sets ovf_err=1; asserting reset_n=0 mid-grant clears every output immediately, without waiting for a clock edge.
